// File: rtl/seqkey_resp_gen.sv
// Bus-snooping security-key responder: a nibble unlock sequence gates LFSR response bits onto the data bus.
// Optional macro RESP_LOCKOUT_EN adds a failed-attempt counter and a sticky LOCKOUT state.
module seqkey_resp_gen #(
  parameter int                   ADDR_W        = 14,
  parameter logic [1:0]           WIN_HI        = 2'b01,
  parameter int                   STATE_W       = 6,
  parameter logic [STATE_W-1:0]   TAPS          = 6'b110000,
  parameter logic [STATE_W-1:0]   SEED          = 6'b000001,
  parameter int                   DATA_W        = 2,
  parameter int                   SEQ_LEN       = 4,
  parameter logic [4*SEQ_LEN-1:0] KEY           = 16'hC3A5,
  parameter logic [3:0]           RELOCK_NIB    = 4'hF,
  parameter int                   LOCKOUT_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              acc_stb,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              unlocked,
  output logic              locked_out
);

  typedef enum logic [1:0] {ST_LOCKED, ST_ARMING, ST_UNLOCKED, ST_LOCKOUT} state_t;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [STATE_W-1:0]   lfsr_q, lfsr_d;
  logic [STATE_W-1:0]   lfsr_step;
  logic [3:0]           nib;
  logic [3:0]           key_nib;
  logic                 qual;

`ifdef RESP_LOCKOUT_EN
  localparam int FAIL_W = $clog2(LOCKOUT_LIMIT + 1);
  logic [FAIL_W-1:0]    fail_cnt_q, fail_cnt_d;
`endif

  assign nib  = addr[7:4];
  assign qual = ~cs_n & rd & (addr[ADDR_W-1:ADDR_W-2] == WIN_HI);

  // Expected nibble for the current sequence position.
  always_comb begin
    key_nib = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx_q == i[3:0]) key_nib = KEY[4*i +: 4];
    end
  end

  // An all-zero register would stick forever, so it reloads the seed instead.
  always_comb begin
    if (lfsr_q == '0) lfsr_step = SEED;
    else              lfsr_step = {lfsr_q[STATE_W-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOCKED;
      idx_q      <= '0;
      lfsr_q     <= SEED;
`ifdef RESP_LOCKOUT_EN
      fail_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lfsr_q     <= lfsr_d;
`ifdef RESP_LOCKOUT_EN
      fail_cnt_q <= fail_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lfsr_d     = lfsr_q;
`ifdef RESP_LOCKOUT_EN
    fail_cnt_d = fail_cnt_q;
`endif
    if (acc_stb && qual) begin
      case (state_q)
        ST_LOCKED, ST_ARMING: begin
          if (nib == key_nib) begin
            if (idx_q == 4'(SEQ_LEN - 1)) begin
              state_d    = ST_UNLOCKED;
              idx_d      = '0;
              lfsr_d     = SEED;
`ifdef RESP_LOCKOUT_EN
              fail_cnt_d = '0;
`endif
            end else begin
              state_d = ST_ARMING;
              idx_d   = idx_q + 4'd1;
            end
          end else begin
            // A wrong nibble that is itself the first key nibble restarts at step one.
            if (nib == KEY[3:0]) begin
              idx_d   = 4'd1;
              state_d = ST_ARMING;
            end else begin
              idx_d   = '0;
              state_d = ST_LOCKED;
            end
`ifdef RESP_LOCKOUT_EN
            if (idx_q != '0 && fail_cnt_q != FAIL_W'(LOCKOUT_LIMIT))
              fail_cnt_d = fail_cnt_q + 1'b1;
            if (fail_cnt_d == FAIL_W'(LOCKOUT_LIMIT))
              state_d = ST_LOCKOUT;
`endif
          end
        end
        ST_UNLOCKED: begin
          if (nib == RELOCK_NIB) begin
            state_d = ST_LOCKED;
            idx_d   = '0;
          end else begin
            lfsr_d  = lfsr_step;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unlocked   = (state_q == ST_UNLOCKED);
`ifdef RESP_LOCKOUT_EN
    locked_out = (state_q == ST_LOCKOUT);
`else
    locked_out = 1'b0;
`endif
    data_oe    = ~rst & qual & (state_q == ST_UNLOCKED) & (nib != RELOCK_NIB);
    data_out   = lfsr_q[DATA_W-1:0];
  end

endmodule

// File: tb/tb_seqkey_resp_gen.sv
// Self-checking bench for seqkey_resp_gen: directed scenarios plus randomized bus traffic against a behavioural model.
module tb_seqkey_resp_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic [13:0] addr = '0;
  logic        rd = 1'b0;
  logic        acc_stb = 1'b0;
  logic [1:0]  data_out;
  logic        data_oe;
  logic        unlocked;
  logic        locked_out;

  int total = 0;
  int bad   = 0;

  // Behavioural model: sequence progress, unlock/lockout flags, LFSR value as an integer.
  int m_prog = 0;
  int m_lfsr = 1;
  int m_fail = 0;
  bit m_unl  = 0;
  bit m_lo   = 0;
  int key_seq[4] = '{5, 10, 3, 12};

  seqkey_resp_gen dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .addr(addr), .rd(rd), .acc_stb(acc_stb),
    .data_out(data_out), .data_oe(data_oe), .unlocked(unlocked), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  function automatic int lfsr_next(int l);
    if (l == 0) return 1;
    return ((l << 1) & 63) | ($countones(l & 'h30) & 1);
  endfunction

  function automatic bit bus_qual();
    return !cs_n && rd && (addr[13:12] == 2'b01);
  endfunction

  function automatic bit exp_oe();
    return !rst && bus_qual() && m_unl && (addr[7:4] != 4'hF);
  endfunction

  task automatic model_update();
    int nib;
    nib = addr[7:4];
    if (rst) begin
      m_prog = 0; m_lfsr = 1; m_fail = 0; m_unl = 0; m_lo = 0;
    end else if (acc_stb && bus_qual() && !m_lo) begin
      if (m_unl) begin
        if (nib == 15) begin m_unl = 0; m_prog = 0; end
        else m_lfsr = lfsr_next(m_lfsr);
      end else if (nib == key_seq[m_prog]) begin
        m_prog++;
        if (m_prog == 4) begin m_unl = 1; m_prog = 0; m_lfsr = 1; m_fail = 0; end
      end else begin
        if (m_prog > 0 && m_fail < 3) m_fail++;
        m_prog = (nib == key_seq[0]) ? 1 : 0;
`ifdef RESP_LOCKOUT_EN
        if (m_fail >= 3) m_lo = 1;
`endif
      end
    end
  endtask

  // Drive one bus cycle and move to the sampling point (falling edge).
  task automatic set_bus(input bit c, input bit r, input logic [1:0] hi, input logic [3:0] nib, input bit s);
    cs_n    = c;
    rd      = r;
    acc_stb = s;
    addr    = {hi, 4'($urandom), nib, 4'($urandom)};
    @(negedge clk);
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic acc(input logic [3:0] nib);
    set_bus(1'b0, 1'b1, 2'b01, nib, 1'b1);
    commit();
  endtask

  task automatic idle();
    set_bus(1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    commit();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    total++; if (data_oe !== 1'b0)     begin bad++; $display("FAIL reset_oe got=%b exp=0", data_oe); end
    total++; if (unlocked !== 1'b0)    begin bad++; $display("FAIL reset_unlocked got=%b exp=0", unlocked); end
    total++; if (data_out !== 2'b01)   begin bad++; $display("FAIL reset_data_out got=%b exp=01", data_out); end
    total++; if (locked_out !== 1'b0)  begin bad++; $display("FAIL reset_locked_out got=%b exp=0", locked_out); end
    commit();
  endtask

  task automatic test_unlock();
    logic [1:0] exp_seq [7];
    exp_seq = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11};
    acc(4'h5); acc(4'hA); acc(4'h3);
    idle();
    total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL unlock_early got=%b exp=0", unlocked); end
    commit();
    acc(4'hC);
    idle();
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL unlock_after_key got=%b exp=1", unlocked); end
    commit();
    for (int k = 0; k < 7; k++) begin
      set_bus(1'b0, 1'b1, 2'b01, 4'h0, 1'b1);
      total++; if (data_oe !== 1'b1) begin bad++; $display("FAIL resp_oe[%0d] got=%b exp=1", k, data_oe); end
      total++; if (data_out !== exp_seq[k]) begin bad++; $display("FAIL resp_data[%0d] got=%b exp=%b", k, data_out, exp_seq[k]); end
      commit();
    end
  endtask

  task automatic test_restart();
    do_reset();
    acc(4'h5);
    set_bus(1'b0, 1'b0, 2'b01, 4'h7, 1'b1); commit();   // write: ignored
    acc(4'hA);
    set_bus(1'b0, 1'b1, 2'b10, 4'h3, 1'b1); commit();   // outside window: ignored
    acc(4'h5); acc(4'hA);
    set_bus(1'b1, 1'b1, 2'b01, 4'h9, 1'b1); commit();   // not selected: ignored
    acc(4'h3);
    idle();
    total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL restart_before_c got=%b exp=0", unlocked); end
    commit();
    acc(4'hC);
    idle();
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL restart_unlock got=%b exp=1", unlocked); end
    commit();
  endtask

  task automatic test_relock();
    set_bus(1'b0, 1'b1, 2'b01, 4'hF, 1'b1);
    total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL relock_oe got=%b exp=0", data_oe); end
    commit();
    idle();
    total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL relock_unlocked got=%b exp=0", unlocked); end
    commit();
    acc(4'h5); acc(4'hA); acc(4'h3); acc(4'hC);
    set_bus(1'b0, 1'b1, 2'b01, 4'h2, 1'b1);
    total++; if (data_oe !== 1'b1)   begin bad++; $display("FAIL reunlock_oe got=%b exp=1", data_oe); end
    total++; if (data_out !== 2'b01) begin bad++; $display("FAIL reunlock_seed got=%b exp=01", data_out); end
    commit();
  endtask

  task automatic test_reset_mid();
    do_reset();
    acc(4'h5); acc(4'hA);
    do_reset();
    acc(4'h3); acc(4'hC);
    idle();
    total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL rst_mid_seq got=%b exp=0", unlocked); end
    commit();
    acc(4'h5); acc(4'hA); acc(4'h3); acc(4'hC); acc(4'h1);
    rst = 1'b1;
    set_bus(1'b0, 1'b1, 2'b01, 4'h1, 1'b1);
    total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_access_oe got=%b exp=0", data_oe); end
    commit();
    rst = 1'b0;
    idle();
    total++; if (unlocked !== 1'b0)  begin bad++; $display("FAIL rst_mid_access_unl got=%b exp=0", unlocked); end
    total++; if (data_out !== 2'b01) begin bad++; $display("FAIL rst_mid_access_lfsr got=%b exp=01", data_out); end
    commit();
  endtask

  task automatic test_lockout();
    bit exp_lo;
`ifdef RESP_LOCKOUT_EN
    exp_lo = 1'b1;
`else
    exp_lo = 1'b0;
`endif
    do_reset();
    for (int a = 0; a < 3; a++) begin acc(4'h5); acc(4'hB); end
    idle();
    total++; if (locked_out !== exp_lo) begin bad++; $display("FAIL lockout_flag got=%b exp=%b", locked_out, exp_lo); end
    commit();
    acc(4'h5); acc(4'hA); acc(4'h3); acc(4'hC);
    set_bus(1'b0, 1'b1, 2'b01, 4'h0, 1'b0);
    total++; if (unlocked !== !exp_lo) begin bad++; $display("FAIL lockout_unlock got=%b exp=%b", unlocked, !exp_lo); end
    total++; if (data_oe !== !exp_lo)  begin bad++; $display("FAIL lockout_oe got=%b exp=%b", data_oe, !exp_lo); end
    commit();
    do_reset();
    idle();
    total++; if (locked_out !== 1'b0) begin bad++; $display("FAIL lockout_cleared got=%b exp=0", locked_out); end
    commit();
  endtask

  task automatic test_random();
    logic [3:0] nib;
    logic [1:0] hi;
    int sel;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 6)       nib = 4'(key_seq[$urandom_range(0, 3)]);
      else if (sel == 6) nib = 4'hF;
      else               nib = 4'($urandom);
      hi = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b01;
      set_bus(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0), hi, nib, ($urandom_range(0, 3) != 0));
      total++;
      if (data_oe !== exp_oe() || data_out !== 2'(m_lfsr) || unlocked !== m_unl || locked_out !== m_lo) begin
        bad++;
        $display("FAIL random[%0d] got oe=%b out=%b unl=%b lo=%b exp oe=%b out=%b unl=%b lo=%b",
                 n, data_oe, data_out, unlocked, locked_out, exp_oe(), 2'(m_lfsr), m_unl, m_lo);
      end
      commit();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_restart();
    test_relock();
    test_reset_mid();
    test_lockout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
